flex_down_counter: RTL and testbench
====================================

# flex_down_counter

Loadable, parameterized down-counter that complements the up-counting flex_counter in the packet processor. Software-visible or FSM-driven logic loads a start value; the block counts down on `count_enable` and pulses `done` on reaching zero. It either stops (one-shot) or reloads the last start value (auto-reload). It times byte and bit windows in the transmit path, where a fixed number of enabled cycles must elapse before the next action.

## Interface
- `NUM_CNT_BITS`, default 4: width of `load_val` and `count_out`; legal range 2–16.

- `clk`, input, 1: single system clock; all state changes on its rising edge.
- `n_rst`, input, 1: reset; synchronous, active-low.
- `clear`, input, 1: synchronous abort to IDLE.
- `load`, input, 1: start or restart with `load_val`.
- `load_val`, input, NUM_CNT_BITS: start value, unsigned; 0 is ignored.
- `count_enable`, input, 1: decrement qualifier, honoured only in RUN.
- `auto_reload`, input, 1: sampled at terminal count; 1 reloads, 0 stops.
- `count_out`, output, NUM_CNT_BITS: current count, registered.
- `busy`, output, 1: high while in RUN.
- `zero_flag`, output, 1: high when `count_out == 0`, decoded from the register.
- `done`, output, 1: registered, one-cycle pulse at each terminal count.

## Operation
- States:
  - IDLE: stopped, `count_out = 0`.
  - RUN: counting.
- Internal `reload_reg` (NUM_CNT_BITS wide) holds the last accepted nonzero `load_val`.
- Priority, evaluated at each rising edge:
  1. `!n_rst`
  2. `clear`
  3. `load`
  4. terminal count
  5. decrement
  6. hold
- Reset (`n_rst == 0` at an edge):
  - `count_out <= 0`, `reload_reg <= 0`, state IDLE, `done <= 0`.
  - Resulting outputs: `busy = 0`, `zero_flag = 1`.
  - Applies mid-count as well.
- `clear`:
  - `count_out <= 0`, state IDLE, `done <= 0`.
  - `reload_reg` is retained.
  - `clear` wins over a simultaneous `load`.
- `load` with `load_val != 0`, in any state:
  - `count_out <= load_val`, `reload_reg <= load_val`, state RUN, `done <= 0`.
  - Same-cycle `count_enable` is ignored; the load does not also decrement.
- `load` with `load_val == 0`: no effect; state, count and `reload_reg` are unchanged. Decrement and terminal-count logic still apply as if `load` were low.
- RUN with `count_enable = 1` and `count_out > 1`: `count_out <= count_out - 1`.
- RUN with `count_enable = 1` and `count_out == 1` (terminal count):
  - Always: `done <= 1`.
  - `auto_reload = 1`: `count_out <= reload_reg`, stay in RUN.
  - `auto_reload = 0`: `count_out <= 0`, go to IDLE.
- RUN with `count_enable = 0`: hold.
- `done` is 0 in every cycle not following a terminal count.
- IDLE ignores `count_enable` and `auto_reload`.
- Arithmetic: unsigned, no wrap. `count_out` never decrements from 0 because RUN never holds 0.

## Timing
- Load to first decrement: the first edge after the load edge with `count_enable` high.
- One-shot period: `load_val` enabled edges after the load edge, then `done` is high for 1 cycle.
- Auto-reload period: exactly `reload_reg` enabled edges between `done` pulses.
- `load_val = 1` with continuous enable and auto-reload: `done` is high every cycle; `count_out` stays 1.
- `done`, `busy` and `count_out` change only at rising edges. `zero_flag` is combinational from the `count_out` register, so it has no input-to-output path.
- `load` in the same cycle as a terminal count: the load wins and `done` stays 0.

## Structure
- Shared package `flex_counter_pkg`: state enum `cnt_state_t {IDLE, RUN}`.
- Single module, no sub-modules: one `always_ff` for state, `count_out`, `reload_reg` and `done`; one `always_comb` for next-state logic.

## Test plan
- Reset: hold `n_rst = 0` for 2 edges mid-count from 9 → `count_out = 0`, `busy = 0`, `zero_flag = 1`, `done = 0`. A one-shot load of 3 afterwards behaves normally.
- One-shot, N=4: load 5, `auto_reload = 0`, continuous enable → `count_out` sequence 5,4,3,2,1,0. `done` is high only in the cycle `count_out` first reads 0; `busy` drops in that same cycle.
- Auto-reload: load 3, `auto_reload = 1`, enable toggled every other cycle → `done` pulses once per 3 enabled edges. `count_out` follows 3,2,1,3,… and never reads 0.
- Gaps and restart: load 6, decrement to 4, drop enable for 5 cycles → holds 4. Assert `load` with 2 → 2 on the next edge, and `done` after 2 enabled edges.
- Priority: `clear` together with `load = 7` → IDLE, `count_out = 0`. `load` together with a terminal count → reloads new value, `done = 0`.
- Ignored load: `load_val = 0` in IDLE → no change. `load_val = 0` in RUN at count 2 with enable → decrements to 1.

Source files
------------

// File: rtl/flex_counter_pkg.sv
// -----------------------------------------------------------------------------
// flex_counter_pkg
// Definitions shared by the flex counter family.
//   cnt_state_t : control state of the down-counter
//                 IDLE = stopped, count is zero
//                 RUN  = counting toward the terminal count
// -----------------------------------------------------------------------------
package flex_counter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } cnt_state_t;

endpackage

// File: rtl/flex_down_counter.sv
// -----------------------------------------------------------------------------
// flex_down_counter
// Loadable down-counter for timing byte and bit windows in the transmit path.
// A nonzero load starts a count. Each enabled edge in RUN decrements it. On
// reaching the terminal count (1 -> next) done pulses for one cycle. The
// counter then either reloads the last start value (auto_reload = 1) or
// returns to IDLE at zero (auto_reload = 0).
//
// Ports
//   clk          : system clock, rising edge
//   n_rst        : synchronous active-low reset
//   clear        : synchronous abort to IDLE (keeps reload_reg)
//   load         : start/restart with load_val (a zero load_val is ignored)
//   load_val     : start value, unsigned, NUM_CNT_BITS wide
//   count_enable : decrement qualifier, honoured only in RUN
//   auto_reload  : sampled at terminal count; 1 reloads, 0 stops
//   count_out    : registered current count
//   busy         : high while in RUN
//   zero_flag    : count_out == 0, decoded from the register
//   done         : registered one-cycle pulse at each terminal count
//
// Handshake: there is no valid/ready pair. load is a single-cycle command
// that is accepted on any edge where it is high, load_val is nonzero and
// clear is low. done is a pulse with no back-pressure.
// -----------------------------------------------------------------------------
module flex_down_counter
  import flex_counter_pkg::*;
#(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    load,
  input  logic [NUM_CNT_BITS-1:0] load_val,
  input  logic                    count_enable,
  input  logic                    auto_reload,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    busy,
  output logic                    zero_flag,
  output logic                    done
);

  localparam logic [NUM_CNT_BITS-1:0] ONE  = NUM_CNT_BITS'(1);
  localparam logic [NUM_CNT_BITS-1:0] ZERO = '0;

  cnt_state_t                state, state_next;
  logic [NUM_CNT_BITS-1:0]   count_next;
  logic [NUM_CNT_BITS-1:0]   reload_reg, reload_next;
  logic                      done_next;
  logic                      load_ok;

  // A load with a zero value is treated exactly as if load were low.
  assign load_ok = load && (load_val != ZERO);

  always_comb begin
    state_next  = state;
    count_next  = count_out;
    reload_next = reload_reg;
    done_next   = 1'b0;

    if (clear) begin
      state_next = IDLE;
      count_next = ZERO;
    end else if (load_ok) begin
      // The load edge never also decrements, even with count_enable high.
      state_next  = RUN;
      count_next  = load_val;
      reload_next = load_val;
    end else if ((state == RUN) && count_enable) begin
      if (count_out == ONE) begin
        done_next = 1'b1;
        if (auto_reload) begin
          // reload_reg is nonzero here: RUN is only entered via a nonzero load.
          count_next = reload_reg;
        end else begin
          state_next = IDLE;
          count_next = ZERO;
        end
      end else begin
        // RUN never holds zero, so this cannot underflow.
        count_next = count_out - ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state      <= IDLE;
      count_out  <= ZERO;
      reload_reg <= ZERO;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      count_out  <= count_next;
      reload_reg <= reload_next;
      done       <= done_next;
    end
  end

  assign busy      = (state == RUN);
  assign zero_flag = (count_out == ZERO);

endmodule

// File: tb/tb_flex_down_counter.sv
// -----------------------------------------------------------------------------
// tb_flex_down_counter
// Bench for flex_down_counter: directed scenarios followed by random traffic.
// The driver pushes the expected post-edge outputs into a queue and a monitor
// pops and compares them after every rising edge.
// -----------------------------------------------------------------------------
module tb_flex_down_counter;

  localparam int W  = 4;
  localparam int EW = W + 3;

  // ---------------------------------------------------------------- clock/reset
  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic         clear = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         count_enable = 1'b0;
  logic         auto_reload = 1'b0;
  logic [W-1:0] count_out;
  logic         busy;
  logic         zero_flag;
  logic         done;

  always #5 clk = ~clk;

  flex_down_counter #(.NUM_CNT_BITS(W)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (clear),
    .load         (load),
    .load_val     (load_val),
    .count_enable (count_enable),
    .auto_reload  (auto_reload),
    .count_out    (count_out),
    .busy         (busy),
    .zero_flag    (zero_flag),
    .done         (done)
  );

  // ---------------------------------------------------------------- reference model
  // Behavioural state: a running flag, the remaining count and the saved
  // start value, updated with plain integer arithmetic.
  int m_count  = 0;
  int m_start  = 0;
  bit m_active = 0;
  bit m_pulse  = 0;

  function automatic void model_edge(input bit rst, input bit clr, input bit ld,
                                     input int lv, input bit en, input bit ar);
    m_pulse = 0;
    if (!rst) begin
      m_count = 0; m_start = 0; m_active = 0;
    end else if (clr) begin
      m_count = 0; m_active = 0;
    end else if (ld && lv != 0) begin
      m_count = lv; m_start = lv; m_active = 1;
    end else if (m_active && en) begin
      m_count = m_count - 1;
      if (m_count == 0) begin
        m_pulse = 1;
        if (ar) m_count = m_start;
        else    m_active = 0;
      end
    end
  endfunction

  // ---------------------------------------------------------------- scoreboard
  logic [EW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int cycle = 0;

  function automatic logic [EW-1:0] pack_exp();
    logic [EW-1:0] e;
    e[EW-1:3] = W'(m_count);
    e[2]      = m_active;
    e[1]      = (m_count == 0);
    e[0]      = m_pulse;
    return e;
  endfunction

  // ---------------------------------------------------------------- driver
  task automatic step(input bit rst, input bit clr, input bit ld, input int lv,
                      input bit en, input bit ar);
    @(negedge clk);
    n_rst        = rst;
    clear        = clr;
    load         = ld;
    load_val     = W'(lv);
    count_enable = en;
    auto_reload  = ar;
    model_edge(rst, clr, ld, lv, en, ar);
    exp_q.push_back(pack_exp());
  endtask

  // plain cycle: no reset, no clear, no load
  task automatic run(input bit en, input bit ar);
    step(1, 0, 0, 0, en, ar);
  endtask

  // ---------------------------------------------------------------- monitor
  always @(posedge clk) begin
    logic [EW-1:0] e;
    #1;
    cycle++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (count_out !== e[EW-1:3]) begin
        bad++;
        $display("FAIL count_out cycle %0d: got %0d expected %0d", cycle, count_out, e[EW-1:3]);
      end
      total++;
      if (busy !== e[2]) begin
        bad++;
        $display("FAIL busy cycle %0d: got %0b expected %0b", cycle, busy, e[2]);
      end
      total++;
      if (zero_flag !== e[1]) begin
        bad++;
        $display("FAIL zero_flag cycle %0d: got %0b expected %0b", cycle, zero_flag, e[1]);
      end
      total++;
      if (done !== e[0]) begin
        bad++;
        $display("FAIL done cycle %0d: got %0b expected %0b", cycle, done, e[0]);
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    // reset state
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1);

    // reset mid-count from 9, then a normal one-shot of 3
    step(1, 0, 1, 9, 0, 0);
    run(1, 0); run(1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(1, 0, 1, 3, 1, 0);
    repeat (5) run(1, 0);

    // one-shot 5: 5,4,3,2,1,0 with done as count first reads 0
    step(1, 0, 1, 5, 1, 0);
    repeat (7) run(1, 0);

    // auto-reload 3 with enable toggling every other cycle
    step(1, 0, 1, 3, 0, 1);
    for (int i = 0; i < 16; i++) run(bit'(i % 2), 1);

    // gaps and restart
    step(1, 0, 1, 6, 0, 0);
    run(1, 0); run(1, 0);
    repeat (5) run(0, 0);
    step(1, 0, 1, 2, 1, 0);
    repeat (4) run(1, 0);

    // clear beats load
    step(1, 0, 1, 4, 1, 1);
    step(1, 1, 1, 7, 1, 1);
    run(1, 1);
    // load together with terminal count: new value, no done
    step(1, 0, 1, 2, 0, 1);
    run(1, 1);
    step(1, 0, 1, 5, 1, 1);
    run(1, 1);

    // ignored zero loads, in IDLE and in RUN
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 1, 1);
    step(1, 0, 1, 3, 0, 0);
    run(1, 0);
    step(1, 0, 1, 0, 1, 0);
    run(1, 0);

    // load_val = 1, auto-reload, continuous enable: done every cycle
    step(1, 0, 1, 1, 1, 1);
    repeat (4) run(1, 1);
    // maximum load value
    step(1, 0, 1, (1 << W) - 1, 1, 0);
    repeat (17) run(1, 0);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 59) != 0),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 7) == 0),
           $urandom_range(0, (1 << W) - 1),
           ($urandom_range(0, 3) != 0),
           $urandom_range(0, 1));
    end

    // drain
    @(negedge clk);
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
